// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: ROM address/data, redirect request and the {pc, instr} handshake to decode.
interface fetch_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 29;

  logic [ADDR_W-1:0] imem_addr_o;
  logic [XLEN-1:0]   imem_instr_i;
  logic              redirect_valid_i;
  logic [XLEN-1:0]   redirect_pc_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [XLEN-1:0]   instr_o;
  logic [XLEN-1:0]   pc_o;

  modport master (
    output imem_addr_o, instr_valid_o, instr_o, pc_o,
    input  imem_instr_i, redirect_valid_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_addr_o, instr_valid_o, instr_o, pc_o,
    output imem_instr_i, redirect_valid_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency ROM and queues {pc, instr}
// in a 2-entry buffer towards decode, with redirect flush of stale fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic    clk_i,
  input  logic    rst_i,
  fetch_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OCC_W = 2;
  localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic            redirect;
  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      demand;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fetch_pc;
  entry_t          new_entry;
  logic            unused_bits;

  // Redirect is ignored while reset is held so the ROM address stays at RESET_PC.
  assign redirect    = bus.redirect_valid_i & ~rst_i;
  assign redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};

  assign bus.instr_valid_o = (occ_q != '0) & ~redirect & ~rst_i;
  assign bus.instr_o       = head_q.instr;
  assign bus.pc_o          = head_q.pc;

  assign pop  = bus.instr_valid_o & bus.instr_ready_i;
  assign push = inflight_q & ~redirect;

  // Slots already committed after this cycle; a new read is only wanted if one stays free.
  assign demand = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign issue  = ~rst_i & (redirect | (demand < 3'd2));

  assign fetch_pc        = redirect ? redirect_pc : pc_q;
  assign bus.imem_addr_o = fetch_pc[30:2];

  assign new_entry = '{pc: inflight_pc_q, instr: bus.imem_instr_i};

  assign unused_bits = ^{bus.redirect_pc_i[1:0], fetch_pc[31], fetch_pc[1:0]};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc;
      pc_d          = fetch_pc + XLEN'(4);
    end
  end

  // Shift-style buffer: pop moves tail to head, push fills the first free slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (redirect) begin
      occ_d = '0;
    end else begin
      if (pop) begin
        head_d = tail_q;
        occ_d  = occ_q - OCC_W'(1);
      end
      if (push) begin
        if (occ_d == '0) begin
          head_d = new_entry;
        end else begin
          tail_d = new_entry;
        end
        occ_d = occ_d + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC_A;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      occ_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      occ_q         <= occ_d;
    end
  end

  a_no_overcommit: assert property (@(posedge clk_i) disable iff (rst_i)
    (3'(occ_q) + 3'(inflight_q)) <= 3'd2);

  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.instr_valid_o && !bus.instr_ready_i) |=> ($stable(bus.pc_o) && $stable(bus.instr_o)));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the synchronous instruction ROM.
- Owns the PC and drives the ROM word address every cycle.
- Captures the ROM data one cycle later, tags it with its PC, and hands {pc, instr} to decode through a valid/ready handshake.
- Includes a 2-entry buffer for back-pressure, plus redirect (branch/jump) flush of stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, first PC fetched after reset (bits [1:0] must be 0).

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
imem_addr_o  output  29  ROM word address [30:2], combinational from PC select
imem_instr_i  input  32  ROM data: word at the address presented on the previous rising edge
redirect_valid_i  input  1  redirect request, one cycle per request
redirect_pc_i  input  32  redirect target
instr_valid_o  output  1  buffer head valid
instr_ready_i  input  1  decode accepts head
instr_o  output  32  head instruction
pc_o  output  32  head PC

Behaviour:
- Reset, asynchronous on rst_i high, effective without a clock edge:
  - pc_q = RESET_PC; inflight_q = 0; buffer empty.
  - instr_valid_o = 0; instr_o = 0; pc_o = 0.
  - imem_addr_o = RESET_PC[30:2]; no issue is counted while rst_i = 1.
- ROM timing: 1-cycle read latency, no enable. Any address presented is read; fetch only tracks whether that read is wanted.
- State:
  - pc_q: next sequential address.
  - inflight_q / inflight_pc_q: a read issued last cycle.
  - occ: 2-entry FIFO occupancy, 0..2.
- pop = instr_valid_o & instr_ready_i.
- issue = !rst_i & (redirect_valid_i | (occ + inflight_q - pop < 2)).
- Address select:
  - Redirect: imem_addr_o = redirect_pc_i[30:2]. On the edge, inflight_q = 1, inflight_pc_q = {redirect_pc_i[31:2], 2'b00}, pc_q = that value + 4.
  - Else: imem_addr_o = pc_q[30:2]. If issue, on the edge inflight_q = 1, inflight_pc_q = pc_q, pc_q += 4. If no issue, pc_q holds and inflight_q = 0.
- Capture: if inflight_q = 1 and no redirect this cycle, push {inflight_pc_q, imem_instr_i} into the FIFO on the edge.
- Redirect (highest priority):
  - In the redirect cycle instr_valid_o is forced 0, so no handshake occurs.
  - On the edge: FIFO emptied, the current in-flight capture discarded, target issued.
  - First target instruction appears at instr_valid_o exactly 2 cycles after the redirect cycle.
  - Back-to-back redirects: the later one wins; the earlier target is never emitted.
  - redirect_pc_i[1:0] are ignored (treated as 0).
- Throughput: with instr_ready_i held 1, one instruction per cycle, no bubbles, after 2-cycle start-up.
- Back-pressure: the FIFO never overflows. occ + inflight_q is never more than 2. Head entry is stable while valid & !ready.
- Simultaneous push and pop with occ = 2 is not reachable (issue was blocked). With occ = 1, push and pop together keep occ = 1.
- Arithmetic:
  - PC increments modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
  - pc_o carries the full 32 bits.
  - imem_addr_o carries bits [30:2] only; bit 31 aliases in the ROM.
- Ordering: pc_o values leave strictly in fetch order. No duplicates or skips except across a redirect.

Test Plan:
1. ROM word 0 = 0x80000537, word 1 = 0x10050513; release reset with ready = 1 -> valid on the 2nd edge after release with pc_o 0x0, instr_o 0x80000537; next cycle pc_o 0x4, instr_o 0x10050513; then one per cycle.
2. ready = 0 for 5 cycles after the first valid -> pc_o/instr_o held at 0x0/0x80000537, occ = 2, imem_addr_o held at 0x2 (pc 0x8); release -> pc_o 0x0, 0x4, 0x8 on consecutive cycles, no gap or repeat.
3. With FIFO full, redirect to 0x20 -> instr_valid_o 0 in the redirect cycle, nothing at pc 0x4/0x8 emitted, pc_o 0x20 with instr 0xffe50283 valid 2 cycles later.
4. Redirect to 0x3E, then redirect to 0x10 the next cycle -> only pc_o 0x10 (instr 0x00000593) appears; a single redirect to 0x3E alone yields pc_o 0x3C, instr 0x0000006f.
5. RESET_PC = 0xFFFF_FFF8 -> imem_addr_o 0x1FFF_FFFE first; pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Assert rst_i mid-stream between edges -> instr_valid_o drops immediately, no clock needed; after release, fetch restarts at RESET_PC with the same 2-cycle latency.
